snake_body_engine: RTL and testbench
====================================

# snake_body_engine

Parametrised snake body engine for the VGA snake game: it holds the snake body in a circular buffer and advances the head one cell per `step` pulse. It erases the tail or grows the snake, detects wall and self collisions, and emits one plot request per changed pixel toward `vga_adapter`. It sits between the game controller and the VGA adapter and replaces the fixed 128-entry shift-register body with a configurable-size grid and length.

## Interface
- `GRID_W`, 160, playfield width in cells
- `GRID_H`, 120, playfield height in cells
- `X_W`, 8, x coordinate width
- `Y_W`, 7, y coordinate width
- `MAX_LEN`, 128, maximum body length; must be a power of two; `AW = $clog2(MAX_LEN)`
- `START_X`, 80, head x after reset
- `START_Y`, 60, head y after reset
- `clkin  in  1  clock`
- `resetn  in  1  reset; synchronous, active-low`
- `step  in  1  single-cycle advance request; sampled only in IDLE`
- `dir  in  2  requested direction: LEFT=0, UP=1, DOWN=2, RIGHT=3`
- `grow  in  1  apple eaten; sampled together with step`
- `x  out  X_W  plot x`
- `y  out  Y_W  plot y`
- `colour  out  3  plot colour: BLACK=000, GREEN=010`
- `plot  out  1  plot strobe, one cycle per pixel`
- `busy  out  1  high whenever state is not IDLE`
- `done  out  1  one-cycle pulse when a step completes`
- `head_x  out  X_W  current head x`
- `head_y  out  Y_W  current head y`
- `len  out  AW+1  current body length`
- `gameover  out  1  sticky collision flag`

## Operation
- States: IDLE, MOVE, ERASE, CHECK, DRAW, DEAD.
- Reset values:
  - `hp`=0, `len`=1, `buf[0]`=(START_X, START_Y), last_dir=RIGHT.
  - `plot`, `busy`, `done`, `gameover` = 0; `x`/`y`/`colour` = 0.
  - `head_x`/`head_y` = START_X/START_Y.
- IDLE:
  - On `step`, latch `dir` and `grow` and go to MOVE.
  - `step` while busy or in DEAD is ignored, not queued.
- MOVE:
  - A latched `dir` that is the reverse of last_dir is replaced by last_dir.
  - Compute the new head. If it leaves the grid (x=0 moving LEFT, x=GRID_W-1 moving RIGHT, y=0 moving UP, y=GRID_H-1 moving DOWN), go to DEAD.
- ERASE:
  - Effective grow = `grow` && `len`<MAX_LEN. At full length `grow` is dropped and `len` saturates.
  - If not growing: plot the tail at `buf[hp-len+1]` (mod MAX_LEN) in BLACK, and set scan count N=`len`-1, excluding the tail because it vacates this step.
  - If growing: no plot, and N=`len`.
- CHECK:
  - Compare the new head against one entry per cycle, starting at `buf[hp]` and walking backward.
  - On a match, go to DEAD immediately. If N=0, pass straight to DRAW.
- DRAW:
  - `hp`<=`hp`+1 (wraps modulo MAX_LEN); write the new head to `buf[hp+1]`.
  - Update `head_x`/`head_y` and last_dir; `len`+=1 if growing.
  - Plot the new head in GREEN; pulse `done`; return to IDLE.
- DEAD:
  - `gameover`=1, no plots. Only `resetn` exits.
  - The head and body are left as they were before the fatal step.
- Reset asserted in any state, including mid-CHECK: next cycle is IDLE with reset values; any pending plot is dropped.

## Timing
- `step` high at cycle 0 (IDLE) gives MOVE at cycle 1, ERASE at cycle 2 (tail `plot` if erasing), CHECK at cycles 3..2+N, and DRAW at cycle 3+N with `plot`+`done`. IDLE follows at cycle 4+N.
- Worst case latency is MAX_LEN+4 cycles. This is well within the slowest rate-divider period.
- All outputs are registered; `x`/`y`/`colour` are valid exactly in the cycle `plot`=1.
- `busy` rises the cycle after `step` is accepted and falls with the return to IDLE.
- `gameover` rises the cycle after the colliding MOVE/CHECK state.

## Configuration
- `SNAKE_WRAP_EN` defined: wall exits wrap instead of killing.
  - x=0 moving LEFT goes to GRID_W-1; x=GRID_W-1 moving RIGHT goes to 0. y likewise with GRID_H.
  - Only self-collision sets `gameover`.
- `SNAKE_WRAP_EN` undefined: wall exit goes to DEAD as specified above.

## Structure
- `snake_pkg` contains:
  - direction localparams (LEFT/UP/DOWN/RIGHT)
  - colour constants (BLACK, GREEN, RED, PURPLE)
  - state encoding
  - the `opposite(dir)` function
- One sub-module, `snake_body_ram`: MAX_LEN x (X_W+Y_W), one synchronous write port, one combinational read port, no reset.
- The engine holds the FSM, pointers, scan counter and wall logic.

## Test plan
- After reset, `step` with dir=RIGHT, grow=0 -> tail plot BLACK at (80,60); GREEN plot at (81,60) at cycle 3; `done` at cycle 3; `len`=1.
- Three steps with grow=1 -> no BLACK plots; `len`=4; head (83,60); each DRAW at cycle 3+`len`_before.
- With dir=RIGHT, request dir=LEFT -> head moves to x+1 (reversal ignored).
- Length 5: UP, LEFT, DOWN -> head hits its own body during CHECK; `gameover`=1; no GREEN plot; further `step` ignored.
- Head at (159,60) moving RIGHT -> without macro `gameover`=1; with `SNAKE_WRAP_EN`, head (0,60) and GREEN plot at (0,60).
- Assert `resetn`=0 during CHECK at `len`=20 -> next cycle IDLE, `plot`=0, `len`=1, head (80,60); `hp` wrap exercised by 200 steps at MAX_LEN=128 with correct tail erase coordinates.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared constants for the snake body engine.
//   - direction codes (LEFT/UP/DOWN/RIGHT)
//   - plot colour codes (BLACK, GREEN, RED, PURPLE)
//   - engine state encoding
//   - opposite(dir): the reverse heading of a direction
package snake_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_PURPLE = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_ERASE,
        ST_CHECK,
        ST_DRAW,
        ST_DEAD
    } state_t;

    // The encoding pairs LEFT/RIGHT and UP/DOWN as bitwise complements.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return ~d;
    endfunction

endpackage

// File: rtl/snake_body_engine_if.sv
// snake_body_engine_if: controller-side command and plot bus of the engine.
//   step/dir/grow : advance request from the game controller
//   busy/done     : engine status toward the controller
//   x/y/colour/plot : one-pixel plot request toward the VGA adapter
// master = game controller / VGA side, slave = snake_body_engine.
interface snake_body_engine_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           step;
    logic [1:0]     dir;
    logic           grow;
    logic           busy;
    logic           done;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [2:0]     colour;
    logic           plot;

    modport master (output step, dir, grow,
                    input  busy, done, x, y, colour, plot);
    modport slave  (input  step, dir, grow,
                    output busy, done, x, y, colour, plot);
endinterface

// File: rtl/snake_body_ram.sv
// snake_body_ram: DEPTH x W body storage.
//   clkin   : clock
//   we_i    : write enable; waddr_i/wdata_i written on the rising edge
//   raddr_i : read address; rdata_o follows it combinationally
// No reset: contents are only meaningful where the engine has written them.
module snake_body_ram #(
    parameter int DEPTH = 128,
    parameter int W     = 15,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clkin,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clkin) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body held in a circular buffer; one head advance
// per accepted step, tail erase or growth, wall and self collision detection,
// one plot request per changed pixel.
// Ports:
//   clkin, resetn    : clock, synchronous active-low reset
//   bus (slave)      : step/dir/grow in; busy/done/x/y/colour/plot out
//   head_x, head_y   : current head cell
//   len              : current body length (1..MAX_LEN)
//   gameover         : sticky collision flag
// Build option: define SNAKE_WRAP_EN to wrap the head around the playfield
// edges instead of dying on a wall exit.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int GRID_W  = 160,
    parameter int GRID_H  = 120,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int MAX_LEN = 128,
    parameter int START_X = 80,
    parameter int START_Y = 60,
    localparam int AW     = $clog2(MAX_LEN)
) (
    input  logic              clkin,
    input  logic              resetn,
    snake_body_engine_if.slave bus,
    output logic [X_W-1:0]    head_x,
    output logic [Y_W-1:0]    head_y,
    output logic [AW:0]       len,
    output logic              gameover
);
    localparam int             XY_W     = X_W + Y_W;
    localparam logic [AW:0]    LEN_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]    CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [X_W-1:0] X_MAX    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(GRID_H - 1);

    state_t         state_q, state_d;
    logic [AW-1:0]  hp_q, hp_d, scan_ptr_q, scan_ptr_d;
    logic [AW:0]    len_q, len_d, scan_cnt_q, scan_cnt_d;
    logic [1:0]     last_dir_q, last_dir_d, dir_q, dir_d;
    logic           grow_q, grow_d;
    logic [X_W-1:0] nx_q, nx_d, head_x_q, head_x_d, x_q, x_d;
    logic [Y_W-1:0] ny_q, ny_d, head_y_q, head_y_d, y_q, y_d;
    logic [2:0]     colour_q, colour_d;
    logic           plot_q, plot_d, done_q, done_d, busy_q, gameover_q;

    logic [1:0]     eff_dir;
    logic           wall_hit, grow_eff;
    logic [X_W-1:0] mx;
    logic [Y_W-1:0] my;
    logic [AW-1:0]  tail_addr, ram_raddr, ram_waddr;
    logic [XY_W-1:0] ram_rdata, ram_wdata;
    logic           ram_we;

    snake_body_ram #(.DEPTH(MAX_LEN), .W(XY_W)) u_ram (
        .clkin   (clkin),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // A direct reversal would drive the head into its own neck; keep going.
    assign eff_dir   = (dir_q == opposite(last_dir_q)) ? last_dir_q : dir_q;
    // Oldest live entry; with a full buffer len[AW-1:0] is 0, giving hp+1.
    assign tail_addr = hp_q - len_q[AW-1:0] + 1'b1;

    // Candidate head; the wrapped coordinate is only kept in wrap builds.
    always_comb begin
        wall_hit = 1'b0;
        mx       = head_x_q;
        my       = head_y_q;
        case (eff_dir)
            DIR_LEFT: begin
                wall_hit = (head_x_q == '0);
                mx       = wall_hit ? X_MAX : head_x_q - 1'b1;
            end
            DIR_RIGHT: begin
                wall_hit = (head_x_q == X_MAX);
                mx       = wall_hit ? '0 : head_x_q + 1'b1;
            end
            DIR_UP: begin
                wall_hit = (head_y_q == '0);
                my       = wall_hit ? Y_MAX : head_y_q - 1'b1;
            end
            default: begin
                wall_hit = (head_y_q == Y_MAX);
                my       = wall_hit ? '0 : head_y_q + 1'b1;
            end
        endcase
    end

    // Reset reseeds buf[0] so the first tail erase finds the start cell.
    always_comb begin
        if (!resetn) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            ram_wdata = {X_W'(START_X), Y_W'(START_Y)};
        end else begin
            ram_we    = (state_q == ST_DRAW);
            ram_waddr = hp_q + 1'b1;
            ram_wdata = {nx_q, ny_q};
        end
    end

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        len_d      = len_q;
        last_dir_d = last_dir_q;
        dir_d      = dir_q;
        grow_d     = grow_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        scan_cnt_d = scan_cnt_q;
        scan_ptr_d = scan_ptr_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        done_d     = 1'b0;
        ram_raddr  = scan_ptr_q;
        grow_eff   = grow_q && (len_q != LEN_FULL);

        case (state_q)
            ST_IDLE: begin
                if (bus.step) begin
                    dir_d   = bus.dir;
                    grow_d  = bus.grow;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                ram_raddr = tail_addr;
                dir_d     = eff_dir;
                nx_d      = mx;
                ny_d      = my;
                grow_d    = grow_eff;
`ifdef SNAKE_WRAP_EN
                state_d   = ST_ERASE;
`else
                state_d   = wall_hit ? ST_DEAD : ST_ERASE;
`endif
                // Tail pixel is registered here so it appears during ERASE.
                if (state_d == ST_ERASE && !grow_eff) begin
                    plot_d   = 1'b1;
                    colour_d = COL_BLACK;
                    x_d      = ram_rdata[XY_W-1:Y_W];
                    y_d      = ram_rdata[Y_W-1:0];
                end
            end
            ST_ERASE: begin
                // The vacating tail is not an obstacle, so skip it.
                scan_cnt_d = grow_q ? len_q : len_q - 1'b1;
                scan_ptr_d = hp_q;
                state_d    = (scan_cnt_d == '0) ? ST_DRAW : ST_CHECK;
            end
            ST_CHECK: begin
                if (ram_rdata == {nx_q, ny_q}) begin
                    state_d = ST_DEAD;
                end else begin
                    scan_cnt_d = scan_cnt_q - 1'b1;
                    scan_ptr_d = scan_ptr_q - 1'b1;
                    if (scan_cnt_q == CNT_ONE) begin
                        state_d = ST_DRAW;
                    end
                end
            end
            ST_DRAW: begin
                hp_d       = hp_q + 1'b1;
                head_x_d   = nx_q;
                head_y_d   = ny_q;
                last_dir_d = dir_q;
                if (grow_q) begin
                    len_d = len_q + 1'b1;
                end
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_DEAD;
            end
        endcase

        // Head pixel and done are registered on entry so they coincide with DRAW.
        if (state_d == ST_DRAW) begin
            plot_d   = 1'b1;
            done_d   = 1'b1;
            colour_d = COL_GREEN;
            x_d      = nx_q;
            y_d      = ny_q;
        end
    end

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            hp_q       <= '0;
            len_q      <= CNT_ONE;
            last_dir_q <= DIR_RIGHT;
            dir_q      <= DIR_RIGHT;
            grow_q     <= 1'b0;
            nx_q       <= '0;
            ny_q       <= '0;
            scan_cnt_q <= '0;
            scan_ptr_q <= '0;
            head_x_q   <= X_W'(START_X);
            head_y_q   <= Y_W'(START_Y);
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= COL_BLACK;
            plot_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            len_q      <= len_d;
            last_dir_q <= last_dir_d;
            dir_q      <= dir_d;
            grow_q     <= grow_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            scan_cnt_q <= scan_cnt_d;
            scan_ptr_q <= scan_ptr_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
            gameover_q <= (state_d == ST_DEAD);
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign len        = len_q;
    assign gameover   = gameover_q;
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine with default parameters.
// Covers reset state, tail erase, growth, reversal, self collision, step
// ignored when dead, reset during CHECK, buffer wrap and the right wall
// (behaviour follows SNAKE_WRAP_EN).
module tb_snake_body_engine;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [7:0] len;
    logic       gameover;

    always #5 clk = ~clk;

    snake_body_engine_if ifc ();

    snake_body_engine dut (
        .clkin    (clk),
        .resetn   (resetn),
        .bus      (ifc),
        .head_x   (head_x),
        .head_y   (head_y),
        .len      (len),
        .gameover (gameover)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         tail_cnt, tail_cyc, green_cnt, draw_cyc, done_cyc, go_cyc;
    logic [7:0] tail_x, draw_x;
    logic [6:0] tail_y, draw_y;
    logic [2:0] draw_col;
    logic       busy1;
    logic       timeout;
    int         bx[$];
    int         by[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        ifc.step = 1'b0;
        ifc.grow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        bx.delete();
        by.delete();
        bx.push_back(80);
        by.push_back(60);
    endtask

    // Issue one step and watch cycles 1.. until done or gameover.
    task automatic run_step(input logic [1:0] d, input logic g);
        tail_cnt = 0; green_cnt = 0;
        tail_cyc = -1; draw_cyc = -1; done_cyc = -1; go_cyc = -1;
        timeout = 1'b0;
        @(negedge clk);
        ifc.step = 1'b1; ifc.dir = d; ifc.grow = g;
        @(negedge clk);
        ifc.step = 1'b0; ifc.grow = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == 1) busy1 = ifc.busy;
            if (ifc.plot === 1'b1) begin
                if (ifc.colour === COL_BLACK) begin
                    tail_cnt++; tail_cyc = c; tail_x = ifc.x; tail_y = ifc.y;
                end else begin
                    green_cnt++; draw_cyc = c; draw_x = ifc.x; draw_y = ifc.y;
                    draw_col = ifc.colour;
                end
            end
            if (ifc.done === 1'b1) done_cyc = c;
            if (gameover === 1'b1) go_cyc = c;
            if (ifc.done === 1'b1 || gameover === 1'b1) break;
            if (c == 300) timeout = 1'b1;
            @(negedge clk);
        end
        chk("step_timeout", timeout, 0);
    endtask

    // One cycle after DRAW the engine must be idle with the new head.
    task automatic idle_chk(input string tag, input int el, input int ex, input int ey);
        @(negedge clk);
        chk({tag, "_busy"}, ifc.busy, 0);
        chk({tag, "_len"}, len, el);
        chk({tag, "_hx"}, head_x, ex);
        chk({tag, "_hy"}, head_y, ey);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nhx, nhy, n, w_evt, w_busy;
        logic [1:0] d;
        logic g;
        logic [1:0] seq [4];

        ifc.step = 1'b0; ifc.dir = DIR_RIGHT; ifc.grow = 1'b0;
        do_reset();

        // Reset state
        chk("rst_plot", ifc.plot, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_gameover", gameover, 0);
        chk("rst_x", ifc.x, 0);
        chk("rst_y", ifc.y, 0);
        chk("rst_colour", ifc.colour, 0);
        chk("rst_hx", head_x, 80);
        chk("rst_hy", head_y, 60);
        chk("rst_len", len, 1);

        // First move right: erase (80,60) at cycle 2, draw (81,60) at cycle 3
        run_step(DIR_RIGHT, 1'b0);
        chk("a_busy1", busy1, 1);
        chk("a_tail_cnt", tail_cnt, 1);
        chk("a_tail_cyc", tail_cyc, 2);
        chk("a_tail_x", tail_x, 80);
        chk("a_tail_y", tail_y, 60);
        chk("a_green_cnt", green_cnt, 1);
        chk("a_draw_cyc", draw_cyc, 3);
        chk("a_draw_x", draw_x, 81);
        chk("a_draw_y", draw_y, 60);
        chk("a_draw_col", draw_col, COL_GREEN);
        chk("a_done_cyc", done_cyc, 3);
        idle_chk("a", 1, 81, 60);

        // Three growth steps: no erase, DRAW at 3+len_before
        for (int k = 0; k < 3; k++) begin
            run_step(DIR_RIGHT, 1'b1);
            chk($sformatf("b%0d_tail_cnt", k), tail_cnt, 0);
            chk($sformatf("b%0d_draw_cyc", k), draw_cyc, 4 + k);
            chk($sformatf("b%0d_draw_x", k), draw_x, 82 + k);
        end
        idle_chk("b", 4, 84, 60);

        // Reversal request LEFT while heading RIGHT keeps going right
        run_step(DIR_LEFT, 1'b0);
        chk("c_tail_x", tail_x, 81);
        chk("c_draw_x", draw_x, 85);
        chk("c_draw_cyc", draw_cyc, 6);
        idle_chk("c", 4, 85, 60);

        run_step(DIR_RIGHT, 1'b1);
        chk("d_draw_cyc", draw_cyc, 7);
        idle_chk("d", 5, 86, 60);

        run_step(DIR_UP, 1'b0);
        chk("e_tail_x", tail_x, 82);
        chk("e_draw_y", draw_y, 59);
        idle_chk("e", 5, 86, 59);

        run_step(DIR_LEFT, 1'b0);
        chk("f_tail_x", tail_x, 83);
        chk("f_draw_x", draw_x, 85);
        idle_chk("f", 5, 85, 59);

        // DOWN into (85,60): found on the 4th CHECK cycle
        run_step(DIR_DOWN, 1'b0);
        chk("g_tail_cnt", tail_cnt, 1);
        chk("g_tail_x", tail_x, 84);
        chk("g_green_cnt", green_cnt, 0);
        chk("g_done_cyc", done_cyc, -1);
        chk("g_go_cyc", go_cyc, 7);
        chk("g_hx", head_x, 85);
        chk("g_hy", head_y, 59);
        chk("g_len", len, 5);

        // Step while dead: no plot, no done, flag stays
        @(negedge clk);
        ifc.step = 1'b1; ifc.dir = DIR_UP;
        @(negedge clk);
        ifc.step = 1'b0;
        w_evt = 0; w_busy = 0;
        for (int c = 0; c < 12; c++) begin
            if (ifc.plot === 1'b1 || ifc.done === 1'b1) w_evt++;
            if (ifc.busy === 1'b1) w_busy++;
            @(negedge clk);
        end
        chk("dead_events", w_evt, 0);
        chk("dead_busy", w_busy, 12);
        chk("dead_gameover", gameover, 1);
        chk("dead_hx", head_x, 85);

        // Reset during CHECK at len=20
        do_reset();
        for (int k = 0; k < 19; k++) run_step(DIR_RIGHT, 1'b1);
        idle_chk("h_pre", 20, 99, 60);
        @(negedge clk);
        ifc.step = 1'b1; ifc.dir = DIR_RIGHT; ifc.grow = 1'b0;
        @(negedge clk);
        ifc.step = 1'b0;
        repeat (9) @(negedge clk);
        chk("h_busy_in_check", ifc.busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("h_busy", ifc.busy, 0);
        chk("h_plot", ifc.plot, 0);
        chk("h_done", ifc.done, 0);
        chk("h_len", len, 1);
        chk("h_hx", head_x, 80);
        chk("h_hy", head_y, 60);

        // 200 steps around a 10x10 square: buffer pointer wraps
        do_reset();
        seq[0] = DIR_RIGHT; seq[1] = DIR_DOWN; seq[2] = DIR_LEFT; seq[3] = DIR_UP;
        for (int i = 0; i < 200; i++) begin
            d = seq[(i / 10) % 4];
            g = (i < 2);
            nhx = bx[$]; nhy = by[$];
            case (d)
                DIR_RIGHT: nhx++;
                DIR_LEFT:  nhx--;
                DIR_UP:    nhy--;
                default:   nhy++;
            endcase
            n = g ? bx.size() : bx.size() - 1;
            run_step(d, g);
            chk($sformatf("w%0d_tail_cnt", i), tail_cnt, g ? 0 : 1);
            if (!g) begin
                chk($sformatf("w%0d_tail_x", i), tail_x, bx[0]);
                chk($sformatf("w%0d_tail_y", i), tail_y, by[0]);
            end
            chk($sformatf("w%0d_draw_x", i), draw_x, nhx);
            chk($sformatf("w%0d_draw_y", i), draw_y, nhy);
            chk($sformatf("w%0d_draw_cyc", i), draw_cyc, 3 + n);
            bx.push_back(nhx); by.push_back(nhy);
            if (!g) begin
                void'(bx.pop_front());
                void'(by.pop_front());
            end
        end
        idle_chk("w_end", 3, 80, 60);

        // Right wall
        do_reset();
        for (int k = 0; k < 79; k++) run_step(DIR_RIGHT, 1'b0);
        idle_chk("j_pre", 1, 159, 60);
        run_step(DIR_RIGHT, 1'b0);
`ifdef SNAKE_WRAP_EN
        chk("j_tail_x", tail_x, 159);
        chk("j_draw_x", draw_x, 0);
        chk("j_draw_y", draw_y, 60);
        chk("j_draw_cyc", draw_cyc, 3);
        chk("j_gameover", gameover, 0);
        idle_chk("j", 1, 0, 60);
`else
        chk("j_go_cyc", go_cyc, 2);
        chk("j_tail_cnt", tail_cnt, 0);
        chk("j_green_cnt", green_cnt, 0);
        chk("j_hx", head_x, 159);
        chk("j_hy", head_y, 60);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
